// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// The RISC-V funct3 size/sign encodings and the FSM state type live here.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes. Only funct3[1:0] matters, so stores and unsigned loads share it.
    function automatic int unsigned size_bytes(input logic [2:0] funct3);
        return 32'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed field of a full cache word
// and sign- or zero-extends it to XLEN according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]               rdata,
    input  logic [$clog2(XLEN/8)-1:0]     off,
    input  logic [2:0]                    funct3,
    output logic [XLEN-1:0]               data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] upper;
    int unsigned     bits;

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        bits    = 8 * size_bytes(funct3);
        if (bits > XLEN) begin
            bits = XLEN;
        end
        // Park the field at the top, then shift back down arithmetically or logically.
        upper = shifted << (XLEN - bits);
        if (funct3[2]) begin
            data = upper >> (XLEN - bits);
        end else begin
            data = $unsigned($signed(upper) >>> (XLEN - bits));
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one committed op per handshake, aligned data-cache
// request, extended load data or store ack, misalignment faults and result backpressure.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic                 op_read,
    input  logic                 op_write,
    input  logic [2:0]           op_funct3,
    input  logic [ADDR_W-1:0]    op_addr,
    input  logic [XLEN-1:0]      op_wdata,
    output logic                 dc_req_valid,
    input  logic                 dc_req_ready,
    output logic                 dc_req_write,
    output logic [ADDR_W-1:0]    dc_req_addr,
    output logic [XLEN-1:0]      dc_req_wdata,
    output logic [XLEN/8-1:0]    dc_req_wstrb,
    input  logic                 dc_resp_valid,
    input  logic [XLEN-1:0]      dc_resp_rdata,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [XLEN-1:0]      res_data,
    output logic                 res_fault
);

    localparam int SB_W  = XLEN / 8;
    localparam int OFF_W = $clog2(SB_W);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   res_data_q, res_data_d;
    logic              res_fault_q, res_fault_d;

    logic              in_is_mem;
    logic              in_is_store;
    int unsigned       in_size;
    logic              in_misaligned;
    logic              in_illegal;
    logic              in_fault;

    logic [OFF_W-1:0]  off_q;
    int unsigned       size_q;
    logic [SB_W-1:0]   strb_base;
    logic [XLEN-1:0]   load_data;

    // A simultaneous read and write is treated as a load.
    always_comb begin
        in_is_mem     = op_read | op_write;
        in_is_store   = op_write & ~op_read;
        in_size       = size_bytes(op_funct3);
        in_misaligned = (op_addr[OFF_W-1:0] & OFF_W'(in_size - 1)) != '0;
        in_illegal    = (op_funct3 == 3'b111)
                      | (in_is_store & op_funct3[2])
                      | ((XLEN == 32) & ((op_funct3 == F3_D) | (op_funct3 == F3_WU)));
        in_fault      = in_misaligned | in_illegal;
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        res_data_d   = res_data_q;
        res_fault_d  = res_fault_q;
        op_ready     = 1'b0;
        dc_req_valid = 1'b0;
        res_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    write_d     = in_is_store;
                    f3_d        = op_funct3;
                    addr_d      = op_addr;
                    wdata_d     = op_wdata;
                    res_data_d  = '0;
                    res_fault_d = 1'b0;
                    if (!in_is_mem) begin
                        state_d = DONE;
                    end else if (in_fault) begin
                        res_fault_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                dc_req_valid = 1'b1;
                if (dc_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses are only looked at here, so strays in other states are dropped.
                if (dc_resp_valid) begin
                    res_data_d = write_q ? '0 : load_data;
                    state_d    = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata  (dc_resp_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        off_q     = addr_q[OFF_W-1:0];
        size_q    = size_bytes(f3_q);
        strb_base = SB_W'((32'd1 << size_q) - 32'd1);

        dc_req_write = dc_req_valid & write_q;
        dc_req_addr  = dc_req_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
        dc_req_wstrb = dc_req_write ? (strb_base << off_q) : '0;
        dc_req_wdata = dc_req_write ? (wdata_q << {off_q, 3'b000}) : '0;
        res_data     = res_valid ? res_data_q : '0;
        res_fault    = res_valid & res_fault_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res_data_q  <= '0;
            res_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            res_data_q  <= res_data_d;
            res_fault_q <= res_fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (XLEN=64): loads, stores, faults,
// backpressure on both handshakes, and reset while a cache response is outstanding.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic        op_read;
    logic        op_write;
    logic [2:0]  op_funct3;
    logic [63:0] op_addr;
    logic [63:0] op_wdata;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_write;
    logic [63:0] dc_req_addr;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_wstrb;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_fault;

    int checks = 0;
    int errors = 0;
    int req_hs = 0;
    int res_hs = 0;
    int hs_req0;
    int hs_res0;

    mem_stage_lsu #(
        .XLEN   (64),
        .ADDR_W (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_read       (op_read),
        .op_write      (op_write),
        .op_funct3     (op_funct3),
        .op_addr       (op_addr),
        .op_wdata      (op_wdata),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_write  (dc_req_write),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_wstrb  (dc_req_wstrb),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_rdata (dc_resp_rdata),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_fault     (res_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes counted mid-cycle, where inputs and outputs are both settled.
    always @(negedge clk) begin
        if (!reset) begin
            if (dc_req_valid && dc_req_ready) req_hs++;
            if (res_valid && res_ready)       res_hs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wdata);
        op_valid  = 1'b1;
        op_read   = rd;
        op_write  = wr;
        op_funct3 = f3;
        op_addr   = addr;
        op_wdata  = wdata;
    endtask

    // Full memory op with a ready cache and a hit one cycle after request accept.
    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                           input logic exp_wr, input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata, input logic [63:0] exp_res);
        drive_op(rd, wr, f3, addr, wdata);
        check({tag, ".op_ready"}, op_ready, 1);
        tick();
        op_valid = 1'b0;
        check({tag, ".req_valid"}, dc_req_valid, 1);
        check({tag, ".req_write"}, dc_req_write, exp_wr);
        check({tag, ".req_addr"},  dc_req_addr, exp_addr);
        check({tag, ".req_wstrb"}, dc_req_wstrb, exp_strb);
        check({tag, ".req_wdata"}, dc_req_wdata, exp_wdata);
        check({tag, ".res_early1"}, res_valid, 0);
        tick();
        dc_resp_valid = 1'b1;
        dc_resp_rdata = rdata;
        check({tag, ".req_dropped"}, dc_req_valid, 0);
        check({tag, ".res_early2"}, res_valid, 0);
        tick();
        dc_resp_valid = 1'b0;
        check({tag, ".res_valid"}, res_valid, 1);
        check({tag, ".res_data"},  res_data, exp_res);
        check({tag, ".res_fault"}, res_fault, 0);
        tick();
        check({tag, ".back_idle"}, op_ready, 1);
        check({tag, ".res_clear"}, res_valid, 0);
    endtask

    // Op that completes without touching the cache (fault or non-memory).
    task automatic run_direct(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] addr, input logic exp_fault);
        hs_req0 = req_hs;
        drive_op(rd, wr, f3, addr, 64'h5555_AAAA_5555_AAAA);
        tick();
        op_valid = 1'b0;
        check({tag, ".res_valid"}, res_valid, 1);
        check({tag, ".res_fault"}, res_fault, exp_fault);
        check({tag, ".res_data"},  res_data, 0);
        check({tag, ".no_req"},    dc_req_valid, 0);
        tick();
        check({tag, ".back_idle"}, op_ready, 1);
        check({tag, ".no_req_hs"}, req_hs - hs_req0, 0);
    endtask

    initial begin
        reset         = 1'b1;
        op_valid      = 1'b0;
        op_read       = 1'b0;
        op_write      = 1'b0;
        op_funct3     = 3'b000;
        op_addr       = '0;
        op_wdata      = '0;
        dc_req_ready  = 1'b1;
        dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        res_ready     = 1'b1;

        tick();
        tick();
        check("rst.op_ready",  op_ready, 1);
        check("rst.req_valid", dc_req_valid, 0);
        check("rst.req_write", dc_req_write, 0);
        check("rst.req_addr",  dc_req_addr, 0);
        check("rst.req_wstrb", dc_req_wstrb, 0);
        check("rst.req_wdata", dc_req_wdata, 0);
        check("rst.res_valid", res_valid, 0);
        check("rst.res_data",  res_data, 0);
        check("rst.res_fault", res_fault, 0);
        reset = 1'b0;
        tick();

        run_mem("lb",  1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
                0, 64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        run_mem("sw",  0, 1, 3'b010, 64'h1004, 64'hDEAD_BEEF, 64'h1111_2222_3333_4444,
                1, 64'h1000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0);
        run_mem("lw",  1, 0, 3'b010, 64'h1004, 64'h0, 64'h8000_0000_0000_0000,
                0, 64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
        run_mem("lhu", 1, 0, 3'b101, 64'h1006, 64'h0, 64'hABCD_0000_0000_0000,
                0, 64'h1000, 8'h00, 64'h0, 64'h0000_0000_0000_ABCD);
        run_mem("lh",  1, 0, 3'b001, 64'h100A, 64'h0, 64'h0000_0000_8001_0000,
                0, 64'h1008, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
        run_mem("lwu", 1, 0, 3'b110, 64'h1000, 64'h0, 64'h1234_5678_8F00_0000,
                0, 64'h1000, 8'h00, 64'h0, 64'h0000_0000_8F00_0000);
        run_mem("sd",  0, 1, 3'b011, 64'h2008, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                1, 64'h2008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
        run_mem("sb",  0, 1, 3'b000, 64'h100D, 64'h1234_5678_9ABC_DEA5, 64'h0,
                1, 64'h1008, 8'h20, 64'hBCDE_A500_0000_0000, 64'h0);
        run_mem("rdwr_ld", 1, 1, 3'b011, 64'h1010, 64'h7777_7777_7777_7777, 64'hFEDC_BA98_7654_3210,
                0, 64'h1010, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210);

        run_direct("lh_misal",  1, 0, 3'b001, 64'h1001, 1);
        run_direct("sw_misal",  0, 1, 3'b010, 64'h1002, 1);
        run_direct("ld_misal",  1, 0, 3'b011, 64'h1004, 1);
        run_direct("f3_111",    1, 0, 3'b111, 64'h1000, 1);
        run_direct("st_f3_u",   0, 1, 3'b100, 64'h1000, 1);
        run_direct("non_mem",   0, 0, 3'b010, 64'h0055, 0);

        // LBU with request and result backpressure; a response during REQ must be ignored.
        hs_req0 = req_hs;
        hs_res0 = res_hs;
        dc_req_ready = 1'b0;
        res_ready    = 1'b0;
        drive_op(1, 0, 3'b100, 64'h1003, 64'h0);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp.req_valid", dc_req_valid, 1);
            check("bp.req_addr",  dc_req_addr, 64'h1000);
            check("bp.req_write", dc_req_write, 0);
            tick();
        end
        dc_req_ready  = 1'b1;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        check("bp.req_valid_hs", dc_req_valid, 1);
        check("bp.req_addr_hs",  dc_req_addr, 64'h1000);
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_rdata = 64'h0000_0000_8000_0000;
        check("bp.wait_no_req", dc_req_valid, 0);
        check("bp.wait_no_res", res_valid, 0);
        tick();
        dc_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp.res_valid", res_valid, 1);
            check("bp.res_data",  res_data, 64'h80);
            check("bp.op_ready",  op_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        check("bp.res_valid_hs", res_valid, 1);
        check("bp.res_data_hs",  res_data, 64'h80);
        tick();
        dc_req_ready = 1'b1;
        check("bp.back_idle", op_ready, 1);
        check("bp.req_hs",    req_hs - hs_req0, 1);
        check("bp.res_hs",    res_hs - hs_res0, 1);

        // Reset while waiting for a response, then a stale response arrives.
        drive_op(1, 0, 3'b011, 64'h3000, 64'h0);
        tick();
        op_valid = 1'b0;
        check("rw.req_valid", dc_req_valid, 1);
        tick();
        reset = 1'b1;
        check("rw.in_wait", dc_req_valid, 0);
        tick();
        reset = 1'b0;
        check("rw.idle",      op_ready, 1);
        check("rw.no_req",    dc_req_valid, 0);
        check("rw.no_res",    res_valid, 0);
        tick();
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'hBADB_ADBA_DBAD_BAD0;
        tick();
        dc_resp_valid = 1'b0;
        check("rw.stale_idle",   op_ready, 1);
        check("rw.stale_no_res", res_valid, 0);
        run_mem("ld_after_rst", 1, 0, 3'b011, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF,
                0, 64'h2000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
